// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings and constants for the fetch/decode sequencer.
package fetch_sequencer_pkg;

   // Fetch FSM state encoding (legacy-compatible plain constants).
   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StFetch  = 3'd1;
   localparam logic [2:0] StDecode = 3'd2;
   localparam logic [2:0] StExec   = 3'd3;
   localparam logic [2:0] StFault  = 3'd4;

   localparam logic [31:0] PcStep   = 32'd4;
   localparam logic [31:0] NopInstr = 32'h0000_0000;

   // Instruction addresses must be word aligned.
   function automatic logic is_aligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the sequencer, imem, the IR and the execute FSM.
interface fetch_sequencer_if;

   logic        enable;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        ir_write;
   logic        decode_valid;
   logic        exec_done;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fault_clear;
   logic [31:0] pc_out;
   logic        fetch_fault;
   logic        busy;

   // Sequencer side.
   modport master (
      input  enable, imem_ready, exec_done, redirect_valid, redirect_pc, fault_clear,
      output imem_req, imem_addr, ir_write, decode_valid, pc_out, fetch_fault, busy
   );

   // Environment side (imem, IR, execute control).
   modport slave (
      output enable, imem_ready, exec_done, redirect_valid, redirect_pc, fault_clear,
      input  imem_req, imem_addr, ir_write, decode_valid, pc_out, fetch_fault, busy
   );

endinterface

// File: rtl/fetch_sequencer_timeout_counter.sv
// Counts FETCH wait cycles; expired flags the last permitted wait cycle.
module fetch_sequencer_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int unsigned   CntW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] count_d, count_q;

   // Next count: clear wins over increment.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + CntW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == CntLast);

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode sequencer: owns the PC, requests imem, loads the IR.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               reset,
   fetch_sequencer_if.master  bus
);

   logic [2:0]  state_d, state_q;
   logic [31:0] pc_d, pc_q;
   logic        cnt_clr, cnt_inc, cnt_expired;

   fetch_sequencer_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .expired (cnt_expired)
   );

   // Next-state, PC update and timeout-counter control.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.enable) state_d = StFetch;
         end
         StFetch: begin
            // A ready on the last permitted cycle beats the timeout.
            if (bus.imem_ready) begin
               state_d = StDecode;
               cnt_clr = 1'b1;
            end else if (cnt_expired) begin
               state_d = StFault;
               cnt_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         StDecode: begin
            state_d = StExec;
         end
         StExec: begin
            if (bus.exec_done) begin
               if (bus.redirect_valid && !is_aligned(bus.redirect_pc)) begin
                  state_d = StFault;
               end else begin
                  pc_d    = bus.redirect_valid ? bus.redirect_pc : pc_q + PcStep;
                  state_d = bus.enable ? StFetch : StIdle;
               end
            end
         end
         StFault: begin
            if (bus.fault_clear) begin
               state_d = StIdle;
               cnt_clr = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and PC registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Outputs decode straight from state so reset clears them asynchronously.
   assign bus.imem_req     = (state_q == StFetch);
   assign bus.imem_addr    = pc_q;
   assign bus.ir_write     = (state_q == StFetch) && bus.imem_ready;
   assign bus.decode_valid = (state_q == StDecode);
   assign bus.pc_out       = pc_q;
   assign bus.fetch_fault  = (state_q == StFault);
   assign bus.busy         = (state_q != StIdle) && (state_q != StFault);

endmodule
